// File: rtl/jk_input_pkg.sv
// Shared types and constants for the J/K input conditioner: pairing FSM states,
// {J,K} command encodings and a counter-width helper.
package jk_input_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SET = 2'd1,
      ST_WAIT_CLR = 2'd2
   } state_e;

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_TOG  = 2'b11;

   // Bits needed to hold any value from 0 up to max(a, b).
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/jk_input_conditioner_debounce_channel.sv
// One button channel: multi-flop synchroniser, consecutive-cycle debounce,
// debounced level and a one-cycle strobe on each accepted press.
module debounce_channel
   import jk_input_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   synced;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_d[gi] = raw;
         end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   assign synced = sync_q[SYNC_STAGES-1];

   // Any agreeing sample restarts the count, so short glitches never flip the level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (synced != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            press_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/jk_input_conditioner.sv
// Debounces set/clear buttons and merges near-simultaneous presses into a toggle,
// emitting single-cycle {J,K} commands for the downstream JK flip-flop.
module jk_input_conditioner
   import jk_input_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PAIR_WINDOW     = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_set_raw,
   input  logic btn_clr_raw,
   output logic J,
   output logic K,
   output logic set_level,
   output logic clr_level,
   output logic busy
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, PAIR_WINDOW);

   logic          set_strobe, clr_strobe;
   state_e        state_q, state_d;
   logic [CW-1:0] win_q, win_d;
   logic [1:0]    cmd_q, cmd_d;

   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_set_channel (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_set_raw),
      .level (set_level),
      .press (set_strobe)
   );

   debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_clr_channel (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_clr_raw),
      .level (clr_level),
      .press (clr_strobe)
   );

   // A partner press wins over window expiry; a repeat of the same button is ignored.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cmd_d   = CMD_HOLD;
      case (state_q)
         ST_IDLE: begin
            if (set_strobe && clr_strobe) begin
               cmd_d = CMD_TOG;
            end else if (set_strobe) begin
               state_d = ST_WAIT_SET;
               win_d   = CW'(PAIR_WINDOW);
            end else if (clr_strobe) begin
               state_d = ST_WAIT_CLR;
               win_d   = CW'(PAIR_WINDOW);
            end
         end
         ST_WAIT_SET: begin
            if (clr_strobe) begin
               cmd_d   = CMD_TOG;
               state_d = ST_IDLE;
               win_d   = '0;
            end else if (win_q == CW'(1)) begin
               cmd_d   = CMD_SET;
               state_d = ST_IDLE;
               win_d   = '0;
            end else begin
               win_d = win_q - 1'b1;
            end
         end
         ST_WAIT_CLR: begin
            if (set_strobe) begin
               cmd_d   = CMD_TOG;
               state_d = ST_IDLE;
               win_d   = '0;
            end else if (win_q == CW'(1)) begin
               cmd_d   = CMD_CLR;
               state_d = ST_IDLE;
               win_d   = '0;
            end else begin
               win_d = win_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            win_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         cmd_q   <= CMD_HOLD;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cmd_q   <= cmd_d;
      end
   end

   assign J    = cmd_q[1];
   assign K    = cmd_q[0];
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Scoreboard bench: press schedules are turned into expected {J,K} commands and
// busy windows from the button/pairing rules, and a monitor checks each pulse.
module tb_jk_input_conditioner;

   localparam int S = 2;
   localparam int D = 4;
   localparam int W = 3;
   localparam int L = 80;

   localparam logic [1:0] E_TOG = 2'b11;
   localparam logic [1:0] E_SET = 2'b10;
   localparam logic [1:0] E_CLR = 2'b01;

   typedef struct {
      int         e;
      logic [1:0] cmd;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic bs = 1'b0;
   logic bc = 1'b0;
   logic J, K, set_level, clr_level, busy;

   int   edge_cnt = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   exp_t sb_q[$];

   bit   set_s[L];
   bit   clr_s[L];
   bit   exp_busy[L];

   jk_input_conditioner #(
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D),
      .PAIR_WINDOW     (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_set_raw (bs),
      .btn_clr_raw (bc),
      .J           (J),
      .K           (K),
      .set_level   (set_level),
      .clr_level   (clr_level),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout edge=%0d", edge_cnt);
      $fatal(1, "watchdog");
   end

   // Monitor: every J/K pulse must match the oldest expected command.
   always @(negedge clk) begin
      if (mon_en && (J || K)) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse edge=%0d got JK=%b required no pulse", edge_cnt, {J, K});
         end else begin
            exp_t x;
            x = sb_q.pop_front();
            if (x.e != edge_cnt || {J, K} != x.cmd) begin
               failures++;
               $display("FAIL cmd_pulse got edge=%0d JK=%b required edge=%0d JK=%b",
                        edge_cnt, {J, K}, x.e, x.cmd);
            end else begin
               $display("pulse edge=%0d JK=%b ok", edge_cnt, {J, K});
            end
         end
      end
   end

   task automatic chk(input string nm, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d edge=%0d", nm, got, req, edge_cnt);
      end
   endtask

   // Build a raw waveform: a few sub-debounce glitches, then a steady hold.
   task automatic fill(input int start, input int nb, input bit is_set);
      int idx;
      int h;
      for (int i = 0; i < L; i++) begin
         if (is_set) set_s[i] = 1'b0; else clr_s[i] = 1'b0;
      end
      if (start < 0) return;
      idx = start;
      for (int b = 0; b < nb; b++) begin
         h = $urandom_range(D - 1, 1);
         for (int i = 0; i < h; i++) begin
            if (is_set) set_s[idx + i] = 1'b1; else clr_s[idx + i] = 1'b1;
         end
         idx += h + $urandom_range(3, 1);
      end
      h = $urandom_range(20, D + 2);
      for (int i = 0; i < h; i++) begin
         if (is_set) set_s[idx + i] = 1'b1; else clr_s[idx + i] = 1'b1;
      end
   endtask

   // Edge at which the pairing logic sees the press: first run of D high samples + S + D.
   function automatic int strobe_rel(input bit is_set);
      int run;
      run = 0;
      for (int i = 0; i < L; i++) begin
         run = (is_set ? set_s[i] : clr_s[i]) ? run + 1 : 0;
         if (run == D) return (i - D + 1) + S + D;
      end
      return -1;
   endfunction

   task automatic push(input int base, input int t, input logic [1:0] c);
      exp_t x;
      x.e   = base + t;
      x.cmd = c;
      sb_q.push_back(x);
   endtask

   task automatic mark_busy(input int from, input int to_excl);
      for (int i = from; i < to_excl; i++) exp_busy[i] = 1'b1;
   endtask

   // Caller must be positioned just after a falling edge.
   task automatic run_txn(input int s_start, input int s_nb, input int c_start, input int c_nb);
      int ts, tc, a, b, base;
      logic [1:0] ca, cb;
      fill(s_start, s_nb, 1'b1);
      fill(c_start, c_nb, 1'b0);
      for (int i = 0; i < L; i++) exp_busy[i] = 1'b0;
      ts   = strobe_rel(1'b1);
      tc   = strobe_rel(1'b0);
      base = edge_cnt + 1;
      if (ts >= 0 && tc >= 0) begin
         if (ts == tc) begin
            push(base, ts, E_TOG);
         end else begin
            a  = (ts < tc) ? ts : tc;
            b  = (ts < tc) ? tc : ts;
            ca = (ts < tc) ? E_SET : E_CLR;
            cb = (ts < tc) ? E_CLR : E_SET;
            if (b - a <= W) begin
               push(base, b, E_TOG);
               mark_busy(a, b);
            end else begin
               push(base, a + W, ca);
               mark_busy(a, a + W);
               push(base, b + W, cb);
               mark_busy(b, b + W);
            end
         end
      end else if (ts >= 0) begin
         push(base, ts + W, E_SET);
         mark_busy(ts, ts + W);
      end else if (tc >= 0) begin
         push(base, tc + W, E_CLR);
         mark_busy(tc, tc + W);
      end
      $display("txn base=%0d set_start=%0d clr_start=%0d set_strobe=%0d clr_strobe=%0d",
               base, s_start, c_start, ts, tc);
      for (int i = 0; i < L; i++) begin
         bs = set_s[i];
         bc = clr_s[i];
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("busy_rel%0d", i), int'(busy), int'(exp_busy[i]));
      end
   endtask

   initial begin
      int base, ok, s0, c0;
      bs = 1'b1;
      bc = 1'b1;
      #1 reset = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_J", int'(J), 0);
      chk("rst_K", int'(K), 0);
      chk("rst_set_level", int'(set_level), 0);
      chk("rst_clr_level", int'(clr_level), 0);
      chk("rst_busy", int'(busy), 0);

      // Both buttons held through reset release: fresh same-edge pair.
      reset = 1'b1;
      base = edge_cnt + 1;
      push(base, S + D, E_TOG);
      $display("txn held_through_reset base=%0d", base);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == S + D - 2) begin
            chk("held_set_level_early", int'(set_level), 0);
            chk("held_clr_level_early", int'(clr_level), 0);
         end
         if (i == S + D - 1) begin
            chk("held_set_level", int'(set_level), 1);
            chk("held_clr_level", int'(clr_level), 1);
         end
         chk("held_busy", int'(busy), 0);
         if (i == 10) begin
            bs = 1'b0;
            bc = 1'b0;
         end
      end

      run_txn(0, 0, -1, 0);
      run_txn(0, 0, 2, 0);
      run_txn(0, 0, W, 0);
      run_txn(W, 0, 0, 0);
      run_txn(0, 0, W + 1, 0);
      run_txn(0, 2, -1, 0);
      run_txn(-1, 0, 0, 3);
      run_txn(5, 0, 5, 0);

      for (int n = 0; n < 30; n++) begin
         s0 = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(20, 0));
         if ($urandom_range(1, 0) == 0 && s0 >= 0) begin
            c0 = s0 + int'($urandom_range(10, 0)) - 5;
            if (c0 < 0) c0 = 0;
         end else begin
            c0 = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(20, 0));
         end
         run_txn(s0, int'($urandom_range(3, 0)), c0, int'($urandom_range(3, 0)));
      end

      // Reset in the middle of a clear window drops the pending command.
      $display("txn mid_window_reset base=%0d", edge_cnt + 1);
      bc = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && ok == 0; i++) begin
         @(negedge clk);
         if (busy) ok = 1;
      end
      chk("midrst_busy_seen", ok, 1);
      @(negedge clk);
      #2 reset = 1'b0;
      bc = 1'b0;
      #1;
      chk("midrst_J", int'(J), 0);
      chk("midrst_K", int'(K), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_clr_level", int'(clr_level), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("midrst_busy_after", int'(busy), 0);
      end

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jk_input_conditioner.md
# jk_input_conditioner

Front-end stage that turns two raw, bouncing push-button inputs (set, clear) into clean single-cycle J/K command pulses for the downstream JK flip-flop stage. Each button is synchronised and debounced. A pairing window merges near-simultaneous set+clear presses into one toggle command (J=K=1). Outside command pulses, J=K=0, so the downstream flip-flop holds its state.

## Interface
- SYNC_STAGES, 2: synchroniser depth per button; ≥2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change; ≥1.
- PAIR_WINDOW, 8: cycles to wait for the partner button after a lone press; ≥1.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is pre-synchronised externally.
- btn_set_raw  input  1  raw set button, asynchronous, active-high.
- btn_clr_raw  input  1  raw clear button, asynchronous, active-high.
- J  output  1  registered command pulse to the JK stage.
- K  output  1  registered command pulse to the JK stage.
- set_level  output  1  debounced set button level.
- clr_level  output  1  debounced clear button level.
- busy  output  1  high while the pairing FSM is waiting for a partner press.

## Operation
- Reset (reset=0): all synchroniser flops, debounce counters, set_level, clr_level, J, K and busy = 0; FSM = IDLE.
- Synchroniser: SYNC_STAGES flops per button; the last stage is the "synced" value.
- Debounce per button:
  - Counter increments on each edge where synced ≠ stable level.
  - Counter clears to 0 on any edge where synced = stable, so a glitch shorter than DEBOUNCE_CYCLES is discarded.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, stable flips and the counter clears.
  - A 0→1 flip raises a one-cycle press strobe in the cycle after the flip. A 1→0 flip (release) generates no event.
- Pairing FSM (states IDLE, WAIT_SET, WAIT_CLR):
  - IDLE, both strobes on the same edge: emit TOGGLE; stay IDLE.
  - IDLE, set strobe only: go to WAIT_SET and load the window counter with PAIR_WINDOW.
  - IDLE, clr strobe only: go to WAIT_CLR and load the window counter with PAIR_WINDOW.
  - WAIT_SET, clr strobe: emit TOGGLE; go to IDLE. This applies even on the expiry edge; partner press has priority over expiry.
  - WAIT_SET, window counter = 1 with no partner strobe: emit SET (J=1, K=0); go to IDLE. Otherwise decrement the counter.
  - WAIT_CLR: symmetric to WAIT_SET; expiry emits CLR (J=0, K=1).
  - A repeat strobe of the same button while waiting is ignored; the window is not restarted.
- Emitted command: J/K registered high for exactly one cycle, then back to 0.
- busy = 1 exactly while the FSM is in WAIT_SET or WAIT_CLR.
- Reset asserted mid-window: the pending command is dropped; no pulse is emitted.
- Button held through reset release: treated as a fresh press after full sync + debounce latency.

## Timing
- Edge 0 = first rising edge sampling raw=1. Let S = SYNC_STAGES, D = DEBOUNCE_CYCLES, W = PAIR_WINDOW.
- Synced value goes high after edge S-1.
- Stable level (set_level/clr_level) goes high after edge S+D-1.
- Press strobe is high during the following cycle; the FSM samples it at edge S+D.
- Same-edge pair: J=K=1 after edge S+D, for one cycle.
- Lone press: busy=1 after edge S+D; command pulse after edge S+D+W, with busy=0 on that same edge.
- Partner strobe sampled at edge S+D+k (1≤k≤W): TOGGLE after that edge.
- Throughput: one command per press; at most one J/K pulse per cycle; minimum spacing between commands is set by the debounce latency.

## Structure
- Package jk_input_pkg:
  - FSM state enum (ST_IDLE, ST_WAIT_SET, ST_WAIT_CLR).
  - Command constants CMD_HOLD=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_TOG=2'b11, encoded as {J,K}.
  - Function computing counter width as clog2 of max(DEBOUNCE_CYCLES, PAIR_WINDOW)+1.
- Sub-module debounce_channel: synchroniser, debounce counter, stable level and press strobe; parameterised by SYNC_STAGES and DEBOUNCE_CYCLES; instantiated twice.
- Top level: two channel instances, pairing FSM, window counter, output registers.

## Test plan
All scenarios use S=2, D=4, W=3.
- Reset: hold reset=0 with both raws=1 → all outputs 0. Release reset → set_level and clr_level rise after edge 5; TOGGLE after edge 6.
- Clean set press at edge 0 → set_level=1 after edge 5, busy=1 after edge 6, J=1/K=0 for one cycle after edge 9, busy=0 after edge 9.
- Bounce: set raw 1,0,1,0 on alternate cycles for 6 cycles, then steady 1 → no J pulse until 4 consecutive synced-high edges have passed, then exactly one SET pulse.
- Pairing: set raw high at edge 0, clr raw high at edge 2 → TOGGLE (J=K=1) one cycle after edge 8; no separate SET pulse.
- Expiry tie: clr strobe arrives on the same edge the set window expires → TOGGLE, not SET.
- Mid-window reset: assert reset during WAIT_CLR → J=K=0 and busy=0 immediately; no pulse after release while buttons stay low.
